clk_trig_decoder: RTL and testbench

// - Receive-side stage for the duty-cycle clock/trigger link: recovers the frame strobe and trigger bit from the combined line.
// - Encoding on the line: 75% duty means trigger=0; 25% duty means trigger=1.
// - Oversamples the combined line on fastclk, measures period and high time per rising edge, and decodes the trigger bit.
// - Tracks link lock; feeds the front-end trigger logic with a fastclk-domain strobe plus trigger bit.

---
 rtl/clk_trig_decoder.sv | 189 ++++++++++++++++++
 tb/tb_clk_trig_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_trig_decoder.sv
// Receive stage for the duty-cycle clock/trigger link: recovers a frame strobe and trigger bit from line_in.
// Define CTD_ERRCNT_EN to add the err_clr input and the saturating 16-bit err_count output.
module clk_trig_decoder #(
    parameter int unsigned PERIOD     = 4,
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned LOS_CYCLES = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        fastclk,
    input  logic        reset,
    input  logic        line_in,
`ifdef CTD_ERRCNT_EN
    input  logic        err_clr,
    output logic [15:0] err_count,
`endif
    output logic        frame_stb,
    output logic        trig_out,
    output logic        trig_level,
    output logic        locked,
    output logic        period_err
);

    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] LOS_VAL = CNT_W'(LOS_CYCLES);
    localparam logic [GW-1:0]    G_ONE   = GW'(1);
    localparam logic [GW-1:0]    G_LAST  = GW'(LOCK_COUNT);

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_t;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             d_prev_q, d_prev_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    state_t           state_q, state_d;
    logic [GW-1:0]    good_cnt_q, good_cnt_d;
    logic             frame_stb_q, frame_stb_d;
    logic             trig_out_q, trig_out_d;
    logic             trig_level_q, trig_level_d;
    logic             locked_q, locked_d;
    logic             period_err_q, period_err_d;

    logic rise, good, bit_dec, los;

    always_comb begin
        s1_d     = line_in;
        s2_d     = s1_q;
        d_prev_d = s2_q;

        rise    = s2_q & ~d_prev_q;
        good    = (per_cnt_q >= P_MIN) && (per_cnt_q <= P_MAX);
        // Duty below 50% decodes as 1; exactly 50% decodes as 0.
        bit_dec = ({hi_cnt_q, 1'b0} < {1'b0, per_cnt_q});
        los     = !rise && (state_q != UNLOCKED) && (per_cnt_q == LOS_VAL);

        if (rise) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            per_cnt_d = (per_cnt_q == CNT_MAX) ? per_cnt_q : per_cnt_q + CNT_ONE;
            hi_cnt_d  = (s2_q && (hi_cnt_q != CNT_MAX)) ? hi_cnt_q + CNT_ONE : hi_cnt_q;
        end

        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        frame_stb_d  = 1'b0;
        trig_out_d   = 1'b0;
        trig_level_d = trig_level_q;
        period_err_d = 1'b0;

        case (state_q)
            UNLOCKED: begin
                if (rise) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ACQUIRE: begin
                if (rise) begin
                    if (good) begin
                        good_cnt_d = good_cnt_q + G_ONE;
                        if (good_cnt_d == G_LAST) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_cnt_d   = '0;
                        period_err_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (good) begin
                        frame_stb_d  = 1'b1;
                        trig_out_d   = bit_dec;
                        trig_level_d = bit_dec;
                    end else begin
                        state_d      = ACQUIRE;
                        good_cnt_d   = '0;
                        period_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = UNLOCKED;
            end
        endcase

        // Loss of signal overrides the state decision; a rise on this edge already suppressed it.
        if (los) begin
            state_d      = UNLOCKED;
            period_err_d = 1'b1;
            trig_level_d = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            d_prev_q     <= 1'b0;
            per_cnt_q    <= '0;
            hi_cnt_q     <= '0;
            state_q      <= UNLOCKED;
            good_cnt_q   <= '0;
            frame_stb_q  <= 1'b0;
            trig_out_q   <= 1'b0;
            trig_level_q <= 1'b0;
            locked_q     <= 1'b0;
            period_err_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            d_prev_q     <= d_prev_d;
            per_cnt_q    <= per_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            frame_stb_q  <= frame_stb_d;
            trig_out_q   <= trig_out_d;
            trig_level_q <= trig_level_d;
            locked_q     <= locked_d;
            period_err_q <= period_err_d;
        end
    end

    assign frame_stb  = frame_stb_q;
    assign trig_out   = trig_out_q;
    assign trig_level = trig_level_q;
    assign locked     = locked_q;
    assign period_err = period_err_q;

`ifdef CTD_ERRCNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Counts on the same edge the period_err pulse is registered.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (period_err_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_clk_trig_decoder.sv
// Bench for clk_trig_decoder: directed line patterns, a per-cycle period/duty model, and literal event counts.
module tb_clk_trig_decoder;

    logic fastclk = 1'b0;
    logic reset   = 1'b1;
    logic line_in = 1'b0;
    logic frame_stb, trig_out, trig_level, locked, period_err;
`ifdef CTD_ERRCNT_EN
    logic        err_clr = 1'b0;
    logic [15:0] err_count;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned cnt_stb = 0, cnt_trig1 = 0, cnt_err = 0;

    clk_trig_decoder #(
        .PERIOD(4),
        .TOL(1),
        .LOCK_COUNT(8),
        .LOS_CYCLES(16),
        .CNT_W(8)
    ) dut (
        .fastclk(fastclk),
        .reset(reset),
        .line_in(line_in),
`ifdef CTD_ERRCNT_EN
        .err_clr(err_clr),
        .err_count(err_count),
`endif
        .frame_stb(frame_stb),
        .trig_out(trig_out),
        .trig_level(trig_level),
        .locked(locked),
        .period_err(period_err)
    );

    always #5 fastclk = ~fastclk;

    task automatic check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    endtask

    // Model: the line is seen two edges late; a period runs from one seen rise to the next.
    localparam int M_UNL = 0, M_ACQ = 1, M_LCK = 2;
    bit smp[$];
    bit effh[$];
    int e_idx, last_r, mode, goodn, m_errcnt;
    int p, h, start;
    bit eff, effp, m_rise, m_good, m_bit, m_los;
    bit m_stb, m_trig, m_level, m_locked, m_err;

    always @(posedge fastclk or posedge reset) begin
        if (reset) begin
            smp.delete();
            effh.delete();
            e_idx = 0; last_r = -1; mode = M_UNL; goodn = 0; m_errcnt = 0;
            m_stb = 0; m_trig = 0; m_level = 0; m_locked = 0; m_err = 0;
        end else begin
            smp.push_back(line_in);
            eff  = (smp.size() >= 3) ? smp[smp.size() - 3] : 1'b0;
            effp = (smp.size() >= 4) ? smp[smp.size() - 4] : 1'b0;
            m_rise = eff && !effp;
            p = e_idx - last_r;
            if (p > 255) p = 255;
            start = (last_r < 0) ? 0 : last_r;
            h = 0;
            for (int i = start; i < e_idx; i++) h += effh[i];
            if (h > 255) h = 255;
            effh.push_back(eff);
            m_good = (p >= 3) && (p <= 5);
            m_bit  = (2 * h < p);
            m_los  = !m_rise && (mode != M_UNL) && (p == 16);
            m_stb = 0; m_trig = 0; m_err = 0;
            if (m_rise) begin
                if (mode == M_UNL) begin
                    mode = M_ACQ; goodn = 0;
                end else if (!m_good) begin
                    mode = M_ACQ; goodn = 0; m_err = 1;
                end else if (mode == M_ACQ) begin
                    goodn++;
                    if (goodn == 8) mode = M_LCK;
                end else begin
                    m_stb = 1; m_trig = m_bit; m_level = m_bit;
                end
                last_r = e_idx;
            end else if (m_los) begin
                mode = M_UNL; m_err = 1; m_level = 0;
            end
            m_locked = (mode == M_LCK);
`ifdef CTD_ERRCNT_EN
            if (err_clr) m_errcnt = 0;
            else if (m_err && m_errcnt < 65535) m_errcnt++;
`endif
            e_idx++;
        end
    end

    always @(negedge fastclk) begin
        if (!reset) begin
            check("frame_stb", frame_stb, m_stb);
            check("trig_out", trig_out, m_trig);
            check("trig_level", trig_level, m_level);
            check("locked", locked, m_locked);
            check("period_err", period_err, m_err);
`ifdef CTD_ERRCNT_EN
            check("err_count", err_count, m_errcnt);
`endif
            if (frame_stb) cnt_stb++;
            if (frame_stb && trig_out) cnt_trig1++;
            if (period_err) cnt_err++;
        end
    end

    task automatic play(input string pat, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < pat.len(); i++) begin
                @(negedge fastclk);
                line_in = (pat[i] == "1");
            end
        end
    endtask

    task automatic snap(input string name, input int exp_locked, input int exp_level);
        @(posedge fastclk);
        #1;
        check({name, "_locked"}, locked, exp_locked);
        check({name, "_level"}, trig_level, exp_level);
    endtask

    task automatic reset_phase(input string name, input int cycles);
        @(negedge fastclk);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge fastclk);
            line_in = ~line_in;
            @(posedge fastclk);
            #1;
            check(name, {frame_stb, trig_out, trig_level, locked, period_err}, 0);
        end
        @(negedge fastclk);
        reset   = 1'b0;
        line_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            @(negedge fastclk);
            line_in = ~line_in;
            @(posedge fastclk);
            #1;
            check("reset_outputs", {frame_stb, trig_out, trig_level, locked, period_err}, 0);
        end
        @(negedge fastclk);
        reset   = 1'b0;
        line_in = 1'b0;

        play("1110", 12);
        snap("after_acquire", 1, 0);

        play("1000", 3);
        play("1100", 2);
        play("11110", 1);
        play("110", 1);

        play("1111110", 1);
        play("1110", 9);
        play("1000", 1);
        play("1110", 1);
        snap("before_los", 1, 1);

        play("0", 20);
        snap("after_los", 0, 0);

        play("1110", 12);
        play("0", 4);
        snap("relocked", 1, 0);

        check("total_frame_stb", cnt_stb, 16);
        check("total_trig1_stb", cnt_trig1, 4);
        check("total_period_err", cnt_err, 2);

        reset_phase("midrun_reset_outputs", 3);
        play("1110", 3);
        snap("after_midrun_reset", 0, 0);

`ifdef CTD_ERRCNT_EN
        reset_phase("errcnt_reset_outputs", 2);
        play("1110", 1);
        play("1111110", 5);
        play("1110", 1);
        @(posedge fastclk);
        #1;
        check("err_count_five", err_count, 5);
        @(negedge fastclk);
        err_clr = 1'b1;
        line_in = 1'b1;
        play("111110", 1);
        play("1110", 1);
        @(negedge fastclk);
        err_clr = 1'b0;
        @(posedge fastclk);
        #1;
        check("err_count_cleared", err_count, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
